timer_counter: RTL

Memory-mapped countdown timer that sits on the system bridge as a responder to the CPU's data-memory-stage bus (address, write enable, write data out, read data back). It decodes word-aligned register accesses and runs a four-state countdown FSM. Its interrupt request feeds one bit of the CPU's `HWint[7:2]` vector.

---
 rtl/timer_counter_pkg.sv | 29 ++
 rtl/timer_counter.sv | 113 +++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared definitions for the memory-mapped countdown timer.
// Holds register word indices, CTRL bit positions, mode encodings and the
// FSM state type used by timer_counter and its testbench.
package timer_counter_pkg;

  // Register word indices (bridge Addr[3:2])
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  // Mode encodings; any value other than MODE_RELOAD runs as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Countdown FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_t;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit countdown timer with interrupt request.
// Ports: clk/reset (sync, active-high); addr/we/wdata bus write side;
// rdata combinational read of the word at addr; irq = irq_flag & IM.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_t   state, state_nxt;
  logic        ctrl_en, en_nxt;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag, flag_nxt;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = we && (addr == TC_CTRL);
  assign preset_wr = we && (addr == TC_PRESET);

  // Next-state logic. The FSM acts on the registered Enable; a CTRL write in
  // the same cycle overrides whatever the FSM wanted for Enable and the flag.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_nxt  = irq_flag;
    en_nxt    = ctrl_en;

    case (state)
      ST_IDLE: begin
        if (ctrl_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // Covers count of 1 and a PRESET of 0
          count_nxt = 32'd0;
          flag_nxt  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_mode == MODE_RELOAD) begin
          flag_nxt  = 1'b0;
          state_nxt = ST_LOAD;
        end else begin
          // One-shot: the flag stays up until software writes CTRL
          en_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (ctrl_wr) begin
      en_nxt   = wdata[CTRL_EN];
      flag_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      irq_flag  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl_en  <= en_nxt;
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      if (ctrl_wr) begin
        ctrl_mode <= wdata[CTRL_MODE_LSB +: 2];
        ctrl_im   <= wdata[CTRL_IM];
      end
      // Only picked up by the next LOAD; a running count is untouched
      if (preset_wr) preset <= wdata;
    end
  end

  // Read mux; COUNT is read-only and the reserved word reads zero
  always_comb begin
    rdata = 32'd0;
    case (addr)
      TC_CTRL:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      TC_PRESET: rdata = preset;
      TC_COUNT:  rdata = count;
      default:   rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag & ctrl_im;

endmodule
